// File: rtl/video_timing_win_gen.sv
// Pixel-clock video timing generator: registered hs/vs/de, frame/line strobes and a
// multiplier-free row-major read address for NUM_WIN horizontally tiled windows.
// Optional macro VTG_WIN_SCALE2X_EN doubles every window on screen (pixel and line repeat).
module video_timing_win_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 72,
    parameter int unsigned H_SYNC   = 80,
    parameter int unsigned H_BLANK  = 368,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BLANK  = 30,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned WIN_X    = 0,
    parameter int unsigned WIN_Y    = 0,
    parameter int unsigned WIN_W    = 640,
    parameter int unsigned WIN_H    = 480,
    parameter int unsigned NUM_WIN  = 2,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic                                             clk_74_25m,
    input  logic                                             rst_n_74_25m,
    input  logic                                             en,
    input  logic                                             restart,
    output logic [$clog2(H_ACTIVE+H_BLANK)-1:0]              h_cnt,
    output logic [$clog2(V_ACTIVE+V_BLANK)-1:0]              v_cnt,
    output logic                                             hs,
    output logic                                             vs,
    output logic                                             de,
    output logic                                             frame_start,
    output logic                                             line_start,
    output logic                                             win_valid,
    output logic [((NUM_WIN > 1) ? $clog2(NUM_WIN) : 1)-1:0] win_id,
    output logic [ADDR_W-1:0]                                win_addr
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int unsigned HC_W    = $clog2(H_TOTAL);
    localparam int unsigned VC_W    = $clog2(V_TOTAL);
    localparam int unsigned ID_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
`ifdef VTG_WIN_SCALE2X_EN
    localparam int unsigned SH      = 1;
`else
    localparam int unsigned SH      = 0;
`endif
    localparam int unsigned W_S     = WIN_W << SH;
    localparam int unsigned H_S     = WIN_H << SH;
    localparam int unsigned CW      = (W_S > 1) ? $clog2(W_S) : 1;

    localparam logic [HC_W-1:0] H_LAST_C   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST_C   = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_C    = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_ACT_C    = VC_W'(V_ACTIVE);
    localparam logic [HC_W-1:0] HS_START_C = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_LEN_C   = HC_W'(H_SYNC);
    localparam logic [VC_W-1:0] VS_START_C = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_LEN_C   = VC_W'(V_SYNC);
    localparam logic [HC_W-1:0] WIN_X_C    = HC_W'(WIN_X);
    localparam logic [HC_W-1:0] X_SPAN_C   = HC_W'(NUM_WIN * W_S);
    localparam logic [VC_W-1:0] WIN_Y_C    = VC_W'(WIN_Y);
    localparam logic [VC_W-1:0] Y_SPAN_C   = VC_W'(H_S);
    localparam logic [CW-1:0]   COL_LAST_C = CW'(W_S - 1);

    if (NUM_WIN < 1 || NUM_WIN > 4) begin : g_err_num_win
        $error("NUM_WIN must be in 1..4");
    end
    if (WIN_X + NUM_WIN * W_S > H_ACTIVE) begin : g_err_win_x
        $error("windows exceed the active line");
    end
    if (WIN_Y + H_S > V_ACTIVE) begin : g_err_win_y
        $error("windows exceed the active frame");
    end
    if (H_FP + H_SYNC > H_BLANK) begin : g_err_h_blank
        $error("H_FP + H_SYNC exceeds H_BLANK");
    end
    if (V_FP + V_SYNC > V_BLANK) begin : g_err_v_blank
        $error("V_FP + V_SYNC exceeds V_BLANK");
    end
    if ((64'd1 << ADDR_W) < 64'(WIN_W) * 64'(WIN_H)) begin : g_err_addr_w
        $error("ADDR_W too small for WIN_W*WIN_H");
    end

    logic [HC_W-1:0]   hc_q, hc_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0] lb_q, lb_d;
    logic              rs_q;
`ifdef VTG_WIN_SCALE2X_EN
    logic              vph_q, vph_d;
`endif

    logic [HC_W-1:0]   x_rel, hs_rel;
    logic [VC_W-1:0]   y_rel, vs_rel;
    logic              in_y, win_hit, new_line;

    logic [HC_W-1:0]   h_cnt_q;
    logic [VC_W-1:0]   v_cnt_q;
    logic              hs_q, vs_q, de_q, fs_q, ls_q, wv_q;
    logic [ID_W-1:0]   win_id_q;
    logic [ADDR_W-1:0] win_addr_q;

    // Unsigned wrap makes (pos - start) < len a single-compare range test.
    always_comb begin
        x_rel   = hc_q - WIN_X_C;
        y_rel   = vc_q - WIN_Y_C;
        hs_rel  = hc_q - HS_START_C;
        vs_rel  = vc_q - VS_START_C;
        in_y    = y_rel < Y_SPAN_C;
        win_hit = (x_rel < X_SPAN_C) && in_y;
    end

    always_comb begin
        hc_d     = hc_q;
        vc_d     = vc_q;
        col_d    = col_q;
        wid_d    = wid_q;
        lb_d     = lb_q;
`ifdef VTG_WIN_SCALE2X_EN
        vph_d    = vph_q;
`endif
        new_line = restart | (en & (hc_q == H_LAST_C));

        if (restart) begin
            hc_d = '0;
            vc_d = '0;
        end else if (en) begin
            if (hc_q == H_LAST_C) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST_C) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end

        // Window state tracks the position held in hc_d/vc_d.
        if (restart | en) begin
            if (hc_d == WIN_X_C) begin
                col_d = '0;
                wid_d = '0;
            end else if (col_q == COL_LAST_C) begin
                col_d = '0;
                wid_d = wid_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (new_line) begin
                if (vc_d == WIN_Y_C) begin
                    lb_d  = '0;
`ifdef VTG_WIN_SCALE2X_EN
                    vph_d = 1'b0;
`endif
                end else if (in_y) begin
`ifdef VTG_WIN_SCALE2X_EN
                    // Each source line is shown twice; advance on the second copy.
                    if (vph_q) begin
                        lb_d = lb_q + ADDR_W'(WIN_W);
                    end
                    vph_d = ~vph_q;
`else
                    lb_d  = lb_q + ADDR_W'(WIN_W);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_74_25m) begin
        if (!rst_n_74_25m) begin
            hc_q  <= '0;
            vc_q  <= '0;
            col_q <= '0;
            wid_q <= '0;
            lb_q  <= '0;
            rs_q  <= 1'b1;
`ifdef VTG_WIN_SCALE2X_EN
            vph_q <= 1'b0;
`endif
        end else begin
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            col_q <= col_d;
            wid_q <= wid_d;
            lb_q  <= lb_d;
            rs_q  <= restart;
`ifdef VTG_WIN_SCALE2X_EN
            vph_q <= vph_d;
`endif
        end
    end

    // Output stage also loads right after a restart/reset so (0,0) appears even with en low.
    always_ff @(posedge clk_74_25m) begin
        if (!rst_n_74_25m) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
            ls_q       <= 1'b0;
            wv_q       <= 1'b0;
            win_id_q   <= '0;
            win_addr_q <= '0;
        end else if (en | rs_q) begin
            h_cnt_q    <= hc_q;
            v_cnt_q    <= vc_q;
            hs_q       <= (hs_rel < HS_LEN_C) ? HS_POL : ~HS_POL;
            vs_q       <= (vs_rel < VS_LEN_C) ? VS_POL : ~VS_POL;
            de_q       <= (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
            fs_q       <= (hc_q == '0) && (vc_q == '0);
            ls_q       <= (hc_q == '0);
            wv_q       <= win_hit;
            win_id_q   <= win_hit ? wid_q : '0;
            win_addr_q <= win_hit ? (lb_q + ADDR_W'(col_q >> SH)) : '0;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign win_valid   = wv_q;
    assign win_id      = win_id_q;
    assign win_addr    = win_addr_q;

endmodule
